// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the one-hot ALU: one op per handshake, result in HOLD until consumed.
// Single-cycle ops give out_valid two cycles after the accept cycle; mul holds start until alu_end or timeout.
module alu_issue_ctrl #(
  parameter int MUL_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [12:0]      in_op,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] out_cycles,
  output logic [12:0]      alu_control,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  input  logic [31:0]      alu_result,
  input  logic             alu_end
);

  typedef enum logic [1:0] {IDLE, EXEC, REL, HOLD} state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(MUL_TIMEOUT);

  state_t           state;
  logic             is_mul;
  logic             flushed;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             op_legal;
  logic             accept;

  assign op_legal = (in_op != '0) && ((in_op & (in_op - 13'd1)) == '0);
  assign accept   = in_valid && in_ready && !flush;
  // Saturating increment: the counter must never wrap past the timeout.
  assign cnt_inc  = (cnt == TMO) ? TMO : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_err     <= '0;
      out_cycles  <= '0;
      alu_control <= '0;
      alu_src1    <= '0;
      alu_src2    <= '0;
      is_mul      <= 1'b0;
      flushed     <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt      <= '0;
            flushed  <= 1'b0;
            is_mul   <= in_op[12];
            in_ready <= 1'b0;
            if (op_legal) begin
              state       <= EXEC;
              alu_control <= in_op;
              alu_src1    <= in_src1;
              alu_src2    <= in_src2;
            end else begin
              state      <= HOLD;
              out_valid  <= 1'b1;
              out_result <= '0;
              out_err    <= 2'b01;
              out_cycles <= '0;
            end
          end
        end
        EXEC: begin
          if (flush) begin
            alu_control <= '0;
            flushed     <= 1'b1;
            if (is_mul) begin
              state <= REL;
            end else begin
              state    <= IDLE;
              in_ready <= 1'b1;
            end
          end else if (!is_mul) begin
            alu_control <= '0;
            out_result  <= alu_result;
            out_err     <= 2'b00;
            out_cycles  <= CNT_W'(1);
            out_valid   <= 1'b1;
            state       <= HOLD;
          end else begin
            cnt <= cnt_inc;
            if (alu_end) begin
              alu_control <= '0;
              out_result  <= alu_result;
              out_err     <= 2'b00;
              out_cycles  <= cnt_inc;
              state       <= REL;
            end else if (cnt_inc == TMO) begin
              alu_control <= '0;
              out_result  <= '0;
              out_err     <= 2'b10;
              out_cycles  <= TMO;
              state       <= REL;
            end
          end
        end
        REL: begin
          // One idle control cycle so the multiplier sees its start bit fall.
          if (flushed || flush) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (flush || out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU stub, vector table, hand sequences and randomized ops.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [1:0]  out_err;
  logic [6:0]  out_cycles;
  logic [12:0] alu_control;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;
  logic        alu_end;

  logic        end_force;
  int          mul_lat;
  int          mul_seen;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.MUL_TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_err(out_err), .out_cycles(out_cycles), .alu_control(alu_control),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result),
    .alu_end(alu_end)
  );

  // ALU behaviour: bit12 mul, 11 add, 10 sub, 9 slt, 8 sltu, 7 and, 6 or, 5 xor,
  // 4 sll, 3 srl, 2 sra, 1 nor, 0 lui; shifts move src2 by src1[4:0].
  function automatic logic [31:0] alu_fn(input logic [12:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    if (op[12]) r = a * b;
    else if (op[11]) r = a + b;
    else if (op[10]) r = a - b;
    else if (op[9])  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    else if (op[8])  r = (a < b) ? 32'd1 : 32'd0;
    else if (op[7])  r = a & b;
    else if (op[6])  r = a | b;
    else if (op[5])  r = a ^ b;
    else if (op[4])  r = b << a[4:0];
    else if (op[3])  r = b >> a[4:0];
    else if (op[2])  r = $unsigned($signed(b) >>> a[4:0]);
    else if (op[1])  r = ~(a | b);
    else if (op[0])  r = b << 12;
    return r;
  endfunction

  always_comb alu_result = alu_fn(alu_control, alu_src1, alu_src2);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) mul_seen <= 0;
    else if (alu_control[12]) mul_seen <= mul_seen + 1;
    else mul_seen <= 0;
  end

  assign alu_end = end_force || (alu_control[12] && mul_lat != 0 && mul_seen + 1 == mul_lat);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [12:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    if (n == 100) check("issue_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [12:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] er, input logic [1:0] ee,
                        input logic [6:0] ec, input int el, input int hold, input string tag);
    int n;
    mul_lat = lat;
    issue(op, a, b);
    check({tag, ".ctl"}, 64'(alu_control), ($countones(op) == 1) ? 64'(op) : 64'd0);
    n = 0;
    while (!out_valid && n < 300) begin step(); n++; end
    check({tag, ".lat"}, 64'(n), 64'(el));
    check({tag, ".res"}, 64'(out_result), 64'(er));
    check({tag, ".err"}, 64'(out_err), 64'(ee));
    check({tag, ".cyc"}, 64'(out_cycles), 64'(ec));
    if (hold > 0) begin
      repeat (hold) step();
      check({tag, ".hold"}, {out_valid, in_ready, out_err, out_result}, {1'b1, 1'b0, ee, er});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".done"}, {out_valid, in_ready}, 2'b01);
  endtask

  typedef struct {
    logic [12:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;
    logic [1:0]  ee;
    logic [6:0]  ec;
    int          el;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int hi;
    vecs[0]  = '{13'h0800, 32'd5, 32'd7, 32'd12, 2'b00, 7'd1, 1};
    vecs[1]  = '{13'h0400, 32'd5, 32'd7, 32'hFFFF_FFFE, 2'b00, 7'd1, 1};
    vecs[2]  = '{13'h0200, 32'hFFFF_FFFF, 32'd1, 32'd1, 2'b00, 7'd1, 1};
    vecs[3]  = '{13'h0100, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'b00, 7'd1, 1};
    vecs[4]  = '{13'h0080, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 2'b00, 7'd1, 1};
    vecs[5]  = '{13'h0020, 32'hAAAA_0000, 32'hFFFF_0000, 32'h5555_0000, 2'b00, 7'd1, 1};
    vecs[6]  = '{13'h0010, 32'd4, 32'd1, 32'd16, 2'b00, 7'd1, 1};
    vecs[7]  = '{13'h0008, 32'd4, 32'h8000_0000, 32'h0800_0000, 2'b00, 7'd1, 1};
    vecs[8]  = '{13'h0001, 32'd0, 32'h0001_2345, 32'h1234_5000, 2'b00, 7'd1, 1};
    vecs[9]  = '{13'h0C00, 32'd5, 32'd7, 32'd0, 2'b01, 7'd0, 0};
    vecs[10] = '{13'h0000, 32'd5, 32'd7, 32'd0, 2'b01, 7'd0, 0};
    vecs[11] = '{13'h1001, 32'd5, 32'd7, 32'd0, 2'b01, 7'd0, 0};

    resetn = 1'b0; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0;
    flush = 1'b0; out_ready = 1'b0; end_force = 1'b0; mul_lat = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.ctl", {in_ready, out_valid, out_err, out_cycles, alu_control},
          {1'b1, 1'b0, 2'b00, 7'd0, 13'd0});
    check("reset.dat", {out_result, alu_src1}, 64'd0);
    resetn = 1'b1;
    step();

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, vecs[i].er, vecs[i].ee, vecs[i].ec,
             vecs[i].el, i % 3, $sformatf("vec%0d", i));

    // Back-pressure: result and in_ready frozen while the consumer stalls.
    issue(13'h0004, 32'd4, 32'h8000_0000);
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp.res%0d", i), 64'(out_result), 64'hF800_0000);
      check($sformatf("bp.rdy%0d", i), {out_valid, in_ready}, 2'b10);
      step();
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    run_op(13'h0800, 32'd100, 32'd23, 0, 32'd123, 2'b00, 7'd1, 1, 0, "bp.next");

    // Mul completing on its 33rd cycle.
    mul_lat = 33;
    issue(13'h1000, 32'd3, 32'hFFFF_FFFF);
    hi = 0;
    while (alu_control[12] && hi < 200) begin hi++; step(); end
    check("mul.high", 64'(hi), 64'd33);
    check("mul.rel", {out_valid, alu_control}, 14'd0);
    step();
    check("mul.out", {out_valid, out_err, out_cycles, out_result}, {1'b1, 2'b00, 7'd33, 32'hFFFF_FFFD});
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Timeout: alu_end never arrives.
    mul_lat = 0;
    issue(13'h1000, 32'd9, 32'd9);
    hi = 0;
    while (alu_control[12] && hi < 200) begin hi++; step(); end
    check("tmo.high", 64'(hi), 64'd64);
    check("tmo.rel", {out_valid, alu_control}, 14'd0);
    step();
    check("tmo.out", {out_valid, out_err, out_cycles, out_result}, {1'b1, 2'b10, 7'd64, 32'd0});
    check("tmo.ctl", 64'(alu_control), 64'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Flush on the 10th mul cycle.
    issue(13'h1000, 32'd2, 32'd2);
    repeat (9) step();
    check("fl.mul10", 64'(alu_control), 64'h1000);
    flush = 1'b1; step(); flush = 1'b0;
    check("fl.drop", {out_valid, alu_control}, 14'd0);
    step();
    check("fl.idle", {out_valid, in_ready}, 2'b01);
    repeat (3) step();
    check("fl.nores", 64'(out_valid), 64'd0);

    // Flush in IDLE blocks acceptance.
    in_valid = 1'b1; in_op = 13'h0800; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    check("fl.idleblk", {in_ready, alu_control}, {1'b1, 13'd0});

    // Flush in HOLD discards the result.
    issue(13'h0800, 32'd1, 32'd1);
    step();
    check("fl.hold0", 64'(out_valid), 64'd1);
    flush = 1'b1; step(); flush = 1'b0;
    check("fl.hold1", {out_valid, in_ready}, 2'b01);

    // Stray alu_end with no mul in flight.
    end_force = 1'b1;
    repeat (3) step();
    end_force = 1'b0;
    check("stray.end", {out_valid, in_ready, alu_control}, {2'b01, 13'd0});

    // Asynchronous reset in the middle of a mul.
    issue(13'h1000, 32'd7, 32'd7);
    repeat (4) step();
    #2 resetn = 1'b0;
    #1;
    check("rst.mid", {out_valid, in_ready, alu_control, out_err, out_cycles}, {2'b01, 13'd0, 2'b00, 7'd0});
    check("rst.dat", {out_result, alu_src2}, 64'd0);
    @(posedge clk); #1 resetn = 1'b1;
    step();

    // Randomized ops against the reference rules.
    for (int k = 0; k < 150; k++) begin
      logic [12:0] op;
      logic [31:0] a, b, er;
      logic [1:0]  ee;
      logic [6:0]  ec;
      int          lat, el, sel;
      a = $urandom; b = $urandom; lat = 0;
      sel = $urandom_range(0, 9);
      if (sel < 7) op = 13'(1) << $urandom_range(0, 11);
      else if (sel < 9) begin op = 13'h1000; lat = $urandom_range(1, 70); end
      else begin
        op = 13'($urandom);
        if ($countones(op) == 1) op = '0;
      end
      if ($countones(op) != 1) begin er = 0; ee = 2'b01; ec = 0; el = 0; end
      else if (!op[12]) begin er = alu_fn(op, a, b); ee = 2'b00; ec = 1; el = 1; end
      else if (lat <= 64) begin er = a * b; ee = 2'b00; ec = 7'(lat); el = lat + 1; end
      else begin er = 0; ee = 2'b10; ec = 7'd64; el = 65; end
      run_op(op, a, b, lat, er, ee, ec, el, $urandom_range(0, 3), $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
